// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter.
//   arb_state_e : arbiter FSM states
//   owner_t     : which requester owns the current transaction
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitR,
        StResp
    } arb_state_e;

    typedef logic owner_t;

    localparam owner_t OWNER_CORE = 1'b0;
    localparam owner_t OWNER_DBG  = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Request/response bus between a requester and a responder.
//   master : drives req/we/addr/wdata/wstrb, receives gnt/rvalid/rdata
//            (err is only meaningful towards requesters and is not routed to the master)
//   slave  : receives req/we/addr/wdata/wstrb, drives gnt/rvalid/rdata/err
interface dmem_arbiter_if #(
    parameter int unsigned ADDR_W = 12
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              gnt;
    logic              rvalid;
    logic [31:0]       rdata;
    logic              err;

    modport master (
        output req, we, addr, wdata, wstrb,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, addr, wdata, wstrb,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/dmem_arbiter_rr_arb2.sv
// Combinational two-way pick between core (bit 0) and debug host (bit 1).
//   i_req        : request vector {m1, m0}
//   i_last_owner : owner of the previous transaction
//   i_fixed_prio : 1 = core wins ties, 0 = alternate on ties
//   o_valid      : at least one request present
//   o_owner      : selected requester
module dmem_arbiter_rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0] i_req,
    input  owner_t     i_last_owner,
    input  logic       i_fixed_prio,
    output logic       o_valid,
    output owner_t     o_owner
);

    always_comb begin
        o_valid = |i_req;
        o_owner = OWNER_CORE;
        case (i_req)
            2'b01:   o_owner = OWNER_CORE;
            2'b10:   o_owner = OWNER_DBG;
            2'b11:   o_owner = i_fixed_prio ? OWNER_CORE : owner_t'(~i_last_owner);
            default: o_owner = OWNER_CORE;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory/IO port between the core LSU (m0) and a debug/loader host (m1).
// One transaction outstanding at a time; each owner gets exactly one rvalid pulse per grant.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   m0, m1        : requester ports (slave side of the bus)
//   mem           : memory port (master side of the bus)
//   busy_o        : high whenever a transaction is in flight
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter bit          FIXED_PRIO = 1'b0,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    dmem_arbiter_if.slave  m0,
    dmem_arbiter_if.slave  m1,
    dmem_arbiter_if.master mem,
    output logic           busy_o
);

    localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

    arb_state_e        r_state, w_state_d;
    owner_t            r_owner, r_last_owner;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;
    logic [7:0]        r_cnt, w_cnt_d;
    logic [31:0]       r_rdata, w_rdata_d;
    logic              r_err, w_err_d;

    logic   w_pick_valid;
    owner_t w_pick;
    logic   w_latch;
    logic   w_issue;
    logic   w_resp;

    dmem_arbiter_rr_arb2 u_pick (
        .i_req        ({m1.req, m0.req}),
        .i_last_owner (r_last_owner),
        .i_fixed_prio (FIXED_PRIO),
        .o_valid      (w_pick_valid),
        .o_owner      (w_pick)
    );

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_rdata_d = r_rdata;
        w_err_d   = r_err;
        w_latch   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_latch   = 1'b1;
                    w_cnt_d   = '0;
                    w_state_d = StIssue;
                end
            end
            StIssue: begin
                if (mem.gnt) begin
                    if (r_we) begin
                        w_rdata_d = '0;
                        w_err_d   = 1'b0;
                        w_state_d = StResp;
                    end else begin
                        w_state_d = StWaitR;
                    end
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                    // Abort once TIMEOUT ungranted cycles have been spent in ISSUE.
                    if (w_cnt_d == TimeoutCnt) begin
                        w_rdata_d = '0;
                        w_err_d   = 1'b1;
                        w_state_d = StResp;
                    end
                end
            end
            StWaitR: begin
                if (mem.rvalid) begin
                    w_rdata_d = mem.rdata;
                    w_err_d   = 1'b0;
                    w_state_d = StResp;
                end
            end
            StResp: begin
                w_cnt_d   = '0;
                w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_rdata <= w_rdata_d;
            r_err   <= w_err_d;
        end
    end

    // Request latch; last_owner resets to the debug host so the core wins the first tie.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_owner      <= OWNER_CORE;
            r_last_owner <= OWNER_DBG;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
        end else if (w_latch) begin
            r_owner      <= w_pick;
            r_last_owner <= w_pick;
            if (w_pick == OWNER_DBG) begin
                r_we    <= m1.we;
                r_addr  <= m1.addr;
                r_wdata <= m1.wdata;
                r_wstrb <= m1.wstrb;
            end else begin
                r_we    <= m0.we;
                r_addr  <= m0.addr;
                r_wdata <= m0.wdata;
                r_wstrb <= m0.wstrb;
            end
        end
    end

    assign w_issue = (r_state == StIssue);
    assign w_resp  = (r_state == StResp);

    assign m0.gnt    = w_latch && (w_pick == OWNER_CORE);
    assign m1.gnt    = w_latch && (w_pick == OWNER_DBG);
    assign m0.rvalid = w_resp && (r_owner == OWNER_CORE);
    assign m1.rvalid = w_resp && (r_owner == OWNER_DBG);
    assign m0.rdata  = m0.rvalid ? r_rdata : '0;
    assign m1.rdata  = m1.rvalid ? r_rdata : '0;
    assign m0.err    = m0.rvalid & r_err;
    assign m1.err    = m1.rvalid & r_err;

    assign mem.req   = w_issue;
    assign mem.we    = w_issue & r_we;
    assign mem.addr  = w_issue ? r_addr : '0;
    assign mem.wdata = w_issue ? r_wdata : '0;
    assign mem.wstrb = w_issue ? r_wstrb : '0;

    assign busy_o = (r_state != StIdle);

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    typedef struct {
        logic        we;
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } memx_t;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } rsp_t;

    logic clk;
    logic rst_n;
    logic busy_a;
    logic busy_b;

    dmem_arbiter_if m0_a ();
    dmem_arbiter_if m1_a ();
    dmem_arbiter_if mem_a ();
    dmem_arbiter_if m0_b ();
    dmem_arbiter_if m1_b ();
    dmem_arbiter_if mem_b ();

    dmem_arbiter #(.ADDR_W(12), .FIXED_PRIO(1'b0), .TIMEOUT(4)) dut_a (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .m0     (m0_a),
        .m1     (m1_a),
        .mem    (mem_a),
        .busy_o (busy_a)
    );

    dmem_arbiter #(.ADDR_W(12), .FIXED_PRIO(1'b1), .TIMEOUT(255)) dut_b (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .m0     (m0_b),
        .m1     (m1_b),
        .mem    (mem_b),
        .busy_o (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Memory model for dut_a: grants while gnt_en, returns rd_data rd_delay cycles after a
    // load grant. Deliberately not reset so that a late response can be produced.
    logic        gnt_en;
    int          rd_delay;
    logic [31:0] rd_data;
    logic        rd_pend = 1'b0;
    int          rd_cnt = 0;

    assign mem_a.gnt    = mem_a.req & gnt_en;
    assign mem_a.rvalid = rd_pend && (rd_cnt == 0);
    assign mem_a.rdata  = mem_a.rvalid ? rd_data : 32'h0BAD_0BAD;
    assign mem_a.err    = 1'b0;

    always @(posedge clk) begin
        if (mem_a.req && mem_a.gnt && !mem_a.we) begin
            rd_pend <= 1'b1;
            rd_cnt  <= rd_delay - 1;
        end else if (rd_pend) begin
            if (rd_cnt == 0) rd_pend <= 1'b0;
            else rd_cnt <= rd_cnt - 1;
        end
    end

    assign mem_b.gnt    = mem_b.req;
    assign mem_b.rvalid = 1'b0;
    assign mem_b.rdata  = 32'h0;
    assign mem_b.err    = 1'b0;

    // Scoreboard queues, filled by stimulus, drained by the monitor.
    int    exp_gnt[$];
    memx_t exp_mem[$];
    rsp_t  exp_rsp[$];
    int    gnt_cyc = 0;
    int    req_hi = 0;
    int    rv_a = 0;
    int    b_gnt0 = 0;
    int    b_gnt1 = 0;
    int    b_rv0 = 0;

    always @(negedge clk) begin
        int    p;
        int    eg;
        memx_t em;
        rsp_t  er;
        #2;
        if (m0_a.gnt || m1_a.gnt) begin
            p = m1_a.gnt ? 1 : 0;
            chk("gnt_onehot", 64'(m0_a.gnt & m1_a.gnt), 64'd0);
            if (exp_gnt.size() == 0) begin
                chk("gnt_pending", 64'(exp_gnt.size()), 64'd1);
            end else begin
                eg = exp_gnt.pop_front();
                chk("gnt_owner", 64'(p), 64'(eg));
            end
            gnt_cyc = cyc;
        end
        if (m0_a.rvalid || m1_a.rvalid) begin
            rv_a++;
            p = m1_a.rvalid ? 1 : 0;
            chk("rvalid_onehot", 64'(m0_a.rvalid & m1_a.rvalid), 64'd0);
            if (exp_rsp.size() == 0) begin
                chk("rsp_pending", 64'(exp_rsp.size()), 64'd1);
            end else begin
                er = exp_rsp.pop_front();
                chk("rsp_port", 64'(p), 64'(er.port));
                chk("rsp_rdata", 64'(p != 0 ? m1_a.rdata : m0_a.rdata), 64'(er.rdata));
                chk("rsp_err", 64'(p != 0 ? m1_a.err : m0_a.err), 64'(er.err));
                chk("nonowner_zero", 64'(p != 0 ? {m0_a.err, m0_a.rdata} : {m1_a.err, m1_a.rdata}),
                    64'd0);
                if (er.lat > 0) chk("rsp_latency", 64'(cyc - gnt_cyc), 64'(er.lat));
            end
        end
        if (mem_a.req) req_hi++;
        else chk("mem_idle_zero", 64'({mem_a.we, mem_a.addr, mem_a.wdata, mem_a.wstrb}), 64'd0);
        if (mem_a.req && mem_a.gnt) begin
            if (exp_mem.size() == 0) begin
                chk("mem_pending", 64'(exp_mem.size()), 64'd1);
            end else begin
                em = exp_mem.pop_front();
                chk("mem_we", 64'(mem_a.we), 64'(em.we));
                chk("mem_addr", 64'(mem_a.addr), 64'(em.addr));
                chk("mem_wdata", 64'(mem_a.wdata), 64'(em.wdata));
                chk("mem_wstrb", 64'(mem_a.wstrb), 64'(em.wstrb));
            end
        end
        if (m0_b.gnt) b_gnt0++;
        if (m1_b.gnt) b_gnt1++;
        if (m0_b.rvalid) b_rv0++;
    end

    function automatic memx_t mk(input logic we, input logic [11:0] a, input logic [31:0] d,
                                 input logic [3:0] s);
        memx_t t;
        t.we = we;
        t.addr = a;
        t.wdata = d;
        t.wstrb = s;
        return t;
    endfunction

    function automatic rsp_t mkr(input int port, input logic [31:0] rdata, input logic err,
                                 input int lat);
        rsp_t r;
        r.port = port;
        r.rdata = rdata;
        r.err = err;
        r.lat = lat;
        return r;
    endfunction

    // Call at a negedge; holds each port's request until it has received its grants.
    task automatic run_pair(input int n0, input memx_t t0, input int n1, input memx_t t1);
        int r0 = n0;
        int r1 = n1;
        int budget = 0;
        m0_a.we = t0.we; m0_a.addr = t0.addr; m0_a.wdata = t0.wdata; m0_a.wstrb = t0.wstrb;
        m1_a.we = t1.we; m1_a.addr = t1.addr; m1_a.wdata = t1.wdata; m1_a.wstrb = t1.wstrb;
        while ((r0 > 0 || r1 > 0) && budget < 200) begin
            m0_a.req = (r0 > 0);
            m1_a.req = (r1 > 0);
            #1;
            if (m0_a.gnt) r0--;
            if (m1_a.gnt) r1--;
            @(negedge clk);
            budget++;
        end
        m0_a.req = 1'b0;
        m1_a.req = 1'b0;
        chk("grant_budget", 64'(r0 + r1), 64'd0);
    endtask

    task automatic wait_idle_a();
        int n = 0;
        while (busy_a && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("idle_budget_a", 64'(busy_a), 64'd0);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish by t=%0t", $time);
        $fatal(1);
    end

    initial begin
        memx_t t0;
        memx_t t1;
        int    base;
        int    n;
        int    budget;

        rst_n = 1'b1;
        m0_a.req = 0; m0_a.we = 0; m0_a.addr = 0; m0_a.wdata = 0; m0_a.wstrb = 0;
        m1_a.req = 0; m1_a.we = 0; m1_a.addr = 0; m1_a.wdata = 0; m1_a.wstrb = 0;
        m0_b.req = 0; m0_b.we = 1; m0_b.addr = 12'h111; m0_b.wdata = 32'h1; m0_b.wstrb = 4'hF;
        m1_b.req = 0; m1_b.we = 1; m1_b.addr = 12'h222; m1_b.wdata = 32'h2; m1_b.wstrb = 4'hF;
        gnt_en = 1'b1;
        rd_delay = 1;
        rd_data = 32'h0;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);

        chk("rst_busy", 64'({busy_a, busy_b}), 64'd0);
        chk("rst_mem_req", 64'({mem_a.req, mem_b.req}), 64'd0);
        chk("rst_mem_bus", 64'({mem_a.we, mem_a.addr, mem_a.wdata, mem_a.wstrb}), 64'd0);
        chk("rst_resp", 64'({m0_a.rvalid, m1_a.rvalid, m0_a.err, m1_a.err}), 64'd0);
        chk("rst_rdata", 64'({m0_a.rdata, m1_a.rdata}), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Simultaneous requests from reset: core first, then alternating.
        t0 = mk(1'b1, 12'h100, 32'h0000_0A0A, 4'hF);
        t1 = mk(1'b1, 12'h200, 32'h0000_0B0B, 4'h1);
        exp_gnt.push_back(0); exp_gnt.push_back(1); exp_gnt.push_back(0); exp_gnt.push_back(1);
        exp_mem.push_back(t0); exp_mem.push_back(t1); exp_mem.push_back(t0); exp_mem.push_back(t1);
        exp_rsp.push_back(mkr(0, 32'h0, 1'b0, 2)); exp_rsp.push_back(mkr(1, 32'h0, 1'b0, 2));
        exp_rsp.push_back(mkr(0, 32'h0, 1'b0, 2)); exp_rsp.push_back(mkr(1, 32'h0, 1'b0, 2));
        run_pair(2, t0, 2, t1);
        wait_idle_a();

        // Core load, zero-wait memory.
        rd_data = 32'hCAFE_F00D;
        t0 = mk(1'b0, 12'h010, 32'h0, 4'h0);
        exp_gnt.push_back(0);
        exp_mem.push_back(t0);
        exp_rsp.push_back(mkr(0, 32'hCAFE_F00D, 1'b0, 3));
        run_pair(1, t0, 0, t0);
        wait_idle_a();

        // Debug store.
        t1 = mk(1'b1, 12'h7F0, 32'h1234_5678, 4'b0011);
        exp_gnt.push_back(1);
        exp_mem.push_back(t1);
        exp_rsp.push_back(mkr(1, 32'h0, 1'b0, 2));
        run_pair(0, t1, 1, t1);
        wait_idle_a();

        // Timeout: memory never grants, abort after 4 ISSUE cycles.
        gnt_en = 1'b0;
        base = req_hi;
        t0 = mk(1'b1, 12'h3C0, 32'hFFFF_0000, 4'hF);
        exp_gnt.push_back(0);
        exp_rsp.push_back(mkr(0, 32'h0, 1'b1, 5));
        run_pair(1, t0, 0, t0);
        wait_idle_a();
        chk("timeout_req_cycles", 64'(req_hi - base), 64'd4);
        gnt_en = 1'b1;
        rd_data = 32'h5A5A_1234;
        t1 = mk(1'b0, 12'h044, 32'h0, 4'h0);
        exp_gnt.push_back(1);
        exp_mem.push_back(t1);
        exp_rsp.push_back(mkr(1, 32'h5A5A_1234, 1'b0, 3));
        run_pair(0, t1, 1, t1);
        wait_idle_a();

        // Reset while waiting for load data; the late memory response must be ignored.
        rd_delay = 5;
        rd_data = 32'hDEAD_BEEF;
        t0 = mk(1'b0, 12'h020, 32'h0, 4'h0);
        exp_gnt.push_back(0);
        exp_mem.push_back(t0);
        base = rv_a;
        run_pair(1, t0, 0, t0);
        @(negedge clk);
        chk("waitr_busy", 64'({busy_a, mem_a.req}), 64'b10);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_waitr_busy", 64'(busy_a), 64'd0);
        chk("rst_waitr_resp", 64'({m0_a.rvalid, m1_a.rvalid, m0_a.rdata}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        chk("late_rvalid_ignored", 64'(rv_a - base), 64'd0);
        chk("late_rvalid_idle", 64'(busy_a), 64'd0);

        // Reset while issuing: mem_req must drop without waiting for a clock.
        gnt_en = 1'b0;
        t1 = mk(1'b1, 12'h0F0, 32'h0000_0001, 4'h1);
        exp_gnt.push_back(1);
        run_pair(0, t1, 1, t1);
        chk("issue_req", 64'(mem_a.req), 64'd1);
        #3 rst_n = 1'b0;
        #1;
        chk("async_req_drop", 64'({mem_a.req, busy_a}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        gnt_en = 1'b1;
        @(negedge clk);

        // Normal service after reset, two-cycle memory read latency.
        rd_delay = 2;
        rd_data = 32'h0F0F_0F0F;
        t0 = mk(1'b0, 12'h024, 32'h0, 4'h0);
        exp_gnt.push_back(0);
        exp_mem.push_back(t0);
        exp_rsp.push_back(mkr(0, 32'h0F0F_0F0F, 1'b0, 4));
        run_pair(1, t0, 0, t0);
        wait_idle_a();

        // Fixed priority: core holds req continuously and wins every time.
        n = 0;
        budget = 0;
        m0_b.req = 1'b1;
        m1_b.req = 1'b1;
        while (n < 4 && budget < 100) begin
            #1;
            if (m0_b.gnt) n++;
            @(negedge clk);
            budget++;
        end
        m0_b.req = 1'b0;
        m1_b.req = 1'b0;
        budget = 0;
        while (busy_b && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        @(negedge clk);
        chk("fp_m0_grants", 64'(b_gnt0), 64'd4);
        chk("fp_m1_grants", 64'(b_gnt1), 64'd0);
        chk("fp_m0_rsp", 64'(b_rv0), 64'd4);

        chk("gnt_q_empty", 64'(exp_gnt.size()), 64'd0);
        chk("mem_q_empty", 64'(exp_mem.size()), 64'd0);
        chk("rsp_q_empty", 64'(exp_rsp.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
